// File: rtl/subset_sum_pkg.sv
// Shared types and constants for the subset-sum triple search.
package subset_sum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int IDX_MAX  = 3;
    localparam int NUM_CAND = 64;
    localparam int IDX_W    = 5;

endpackage

// File: rtl/subset_sum_search_partial_sum.sv
// Combinational partial-sum checker: flags a candidate triple whose sum hits the target
// and which is not one of the excluded degenerate shapes.
module subset_sum_search_partial_sum
    import subset_sum_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    input  logic [IDX_W-1:0] c,
    input  logic [IDX_W-1:0] target,
    output logic             match
);

    logic [IDX_W-1:0] psum;
    logic             sum_hit;
    logic             degenerate;

    always_comb begin
        psum       = a + b + c;
        sum_hit    = (psum == target);
        // Triples with two zero leading terms, or a zero head and a repeated tail, are rejected
        degenerate = ((a == '0) && (b == '0)) ||
                     ((a == '0) && (c == '0)) ||
                     ((a == '0) && (b == c));
        match      = sum_hit && !degenerate;
    end

endmodule

// File: rtl/subset_sum_search.sv
// Sequential search over all 64 index triples (a,b,c) in 0..3, counting or stopping
// at triples accepted by the partial-sum checker.
module subset_sum_search
    import subset_sum_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             first_only,
    input  logic             abort,
    input  logic [4:0]       target,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [4:0]       sol_a,
    output logic [4:0]       sol_b,
    output logic [4:0]       sol_c,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IDX_MAX);

    state_t           state;
    logic [IDX_W-1:0] cand_a;
    logic [IDX_W-1:0] cand_b;
    logic [IDX_W-1:0] cand_c;
    logic [IDX_W-1:0] tgt_q;
    logic             first_only_q;
    logic             match;
    logic             last_cand;

    subset_sum_search_partial_sum u_check (
        .a      (cand_a),
        .b      (cand_b),
        .c      (cand_c),
        .target (tgt_q),
        .match  (match)
    );

    assign last_cand = (cand_a == IDX_LAST) && (cand_b == IDX_LAST) && (cand_c == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            sol_a        <= '0;
            sol_b        <= '0;
            sol_c        <= '0;
            match_cnt    <= '0;
            cand_a       <= '0;
            cand_b       <= '0;
            cand_c       <= '0;
            tgt_q        <= '0;
            first_only_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q        <= target;
                        first_only_q <= first_only;
                        found        <= 1'b0;
                        sol_a        <= '0;
                        sol_b        <= '0;
                        sol_c        <= '0;
                        match_cnt    <= '0;
                        cand_a       <= '0;
                        cand_b       <= '0;
                        cand_c       <= '0;
                        busy         <= 1'b1;
                        state        <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Abort takes priority over any match seen in the same cycle
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (match) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (!found) begin
                                found <= 1'b1;
                                sol_a <= cand_a;
                                sol_b <= cand_b;
                                sol_c <= cand_c;
                            end
                        end
                        if (last_cand || (match && first_only_q)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (cand_c == IDX_LAST) begin
                            // c runs fastest, then b, then a
                            cand_c <= '0;
                            if (cand_b == IDX_LAST) begin
                                cand_b <= '0;
                                cand_a <= cand_a + 1'b1;
                            end else begin
                                cand_b <= cand_b + 1'b1;
                            end
                        end else begin
                            cand_c <= cand_c + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subset_sum_search.sv
// Randomized and directed bench for subset_sum_search against an enumeration model.
module tb_subset_sum_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       first_only;
    logic       abort;
    logic [4:0] target;
    logic       busy;
    logic       done;
    logic       found;
    logic [4:0] sol_a;
    logic [4:0] sol_b;
    logic [4:0] sol_c;
    logic [6:0] match_cnt;

    int n_tests;
    int n_fail;

    subset_sum_search #(.CNT_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_only (first_only),
        .abort      (abort),
        .target     (target),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .sol_a      (sol_a),
        .sol_b      (sol_b),
        .sol_c      (sol_c),
        .match_cnt  (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk k = 16a+4b+c, stop on abort (cycle ab covers candidate ab-1) or first match.
    task automatic model(input int tgt, input bit fo, input int ab,
                         output bit aborted, output int done_cyc,
                         output bit m_found, output int m_cnt, output int m_sol);
        aborted  = 0;
        done_cyc = 65;
        m_found  = 0;
        m_cnt    = 0;
        m_sol    = 0;
        for (int k = 0; k < 64; k++) begin
            int a, b, c;
            bit hit;
            a = k / 16;
            b = (k / 4) % 4;
            c = k % 4;
            if (ab != 0 && k == ab - 1) begin
                aborted = 1;
                break;
            end
            hit = (((a + b + c) % 32) == tgt) && !(a == 0 && b == 0) &&
                  !(a == 0 && c == 0) && !(a == 0 && b == c);
            if (hit) begin
                m_cnt++;
                if (!m_found) begin
                    m_found = 1;
                    m_sol   = a * 1024 + b * 32 + c;
                end
                if (fo) begin
                    done_cyc = k + 2;
                    break;
                end
            end
        end
    endtask

    // ab: cycle in which abort is held (0 = never); st: cycle of an extra, ignored start pulse.
    task automatic run(input int tgt, input bit fo, input int ab, input int st);
        bit aborted, e_found, got_done;
        int e_done, e_cnt, e_sol, e, end_cyc;
        model(tgt, fo, ab, aborted, e_done, e_found, e_cnt, e_sol);
        start      = 1'b1;
        target     = 5'(tgt);
        first_only = fo;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0;
        got_done = 0;
        end_cyc = 0;
        chk("busy_after_start", busy, 1);
        chk("cnt_cleared", match_cnt, 0);
        chk("found_cleared", found, 0);
        forever begin
            abort = (ab != 0 && ab == e + 1);
            if (st != 0 && st == e + 1) begin
                start      = 1'b1;
                target     = 5'd9;
                first_only = ~fo;
            end
            @(posedge clk); #1;
            e++;
            abort = 1'b0;
            start = 1'b0;
            if (done) begin
                got_done = 1;
                end_cyc  = e + 1;
                break;
            end
            if (!busy) begin
                end_cyc = e + 1;
                break;
            end
            if (e > 80) begin
                chk("timeout", 1, 0);
                break;
            end
        end
        if (aborted) begin
            chk("abort_no_done", got_done, 0);
            chk("abort_idle_cycle", end_cyc, ab + 1);
        end else begin
            chk("done_seen", got_done, 1);
            chk("done_cycle", end_cyc, e_done);
            chk("busy_in_done", busy, 0);
        end
        chk("found", found, e_found);
        chk("match_cnt", match_cnt, e_cnt);
        chk("sol", {sol_a, sol_b, sol_c}, e_sol);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("cnt_held", match_cnt, e_cnt);
        chk("sol_held", {sol_a, sol_b, sol_c}, e_sol);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        first_only = 1'b0;
        abort      = 1'b0;
        target     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_sol", {sol_a, sol_b, sol_c}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(3, 0, 0, 0);
        run(3, 1, 0, 0);
        run(0, 0, 0, 0);
        run(9, 0, 0, 0);
        run(9, 1, 0, 0);
        run(12, 0, 0, 0);
        run(3, 0, 5, 3);
        run(3, 1, 7, 0);

        // Reset mid-search must clear everything at once
        start      = 1'b1;
        target     = 5'd3;
        first_only = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_found", found, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_found", found, 0);
        chk("async_rst_cnt", match_cnt, 0);
        chk("async_rst_sol", {sol_a, sol_b, sol_c}, 0);
        chk("async_rst_done", done, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(3, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            int t, ab;
            bit fo;
            t  = $urandom_range(0, 15);
            fo = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 66) : 0;
            run(t, fo, ab, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/subset_sum_search.md
SUBSET_SUM_SEARCH -- requirements
Module: subset_sum_search

Interface
REQ-001 The block SHALL have parameter CNT_W, default 7, as the width of the match counter (enough for 64 candidates).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a search; sampled only in IDLE.
REQ-005 The block SHALL have port first_only, input, 1 bit: 1 stops at the first match, 0 counts all matches; latched with start.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates an active search.
REQ-007 The block SHALL have port target, input, 5 bits: the partial-sum value psum; latched with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SEARCH.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a search completes.
REQ-010 The block SHALL have port found, output, 1 bit: at least one match seen in the last search.
REQ-011 The block SHALL have ports sol_a, sol_b and sol_c, outputs, 5 bits each: the first matching triple.
REQ-012 The block SHALL have port match_cnt, output, CNT_W bits: the number of matches seen.

Function
REQ-013 The FSM SHALL have the states IDLE, SEARCH and DONE.
REQ-014 In IDLE with start=1, the block SHALL at that edge:
- latch target and first_only;
- clear found, sol_* and match_cnt;
- load candidate (0,0,0);
- enter SEARCH.
REQ-015 start while in SEARCH or DONE SHALL be ignored.
REQ-016 In SEARCH, the block SHALL evaluate one candidate (a,b,c) per cycle, each index in 0..3 zero-extended to 5 bits.
REQ-017 Enumeration order SHALL be c fastest, then b, then a; the candidate index is k = 16a + 4b + c, from 0 to 63.
REQ-018 Match SHALL be defined as all of:
- a + b + c == target, computed in 5-bit arithmetic;
- NOT(a==b==0);
- NOT(a==c==0);
- NOT(b==c and a==0).
REQ-019 Each match SHALL increment match_cnt at the edge ending that candidate.
REQ-020 Only the first match SHALL set found=1 and capture sol_a, sol_b and sol_c.
REQ-021 SEARCH SHALL go to DONE after candidate 63, or after the first match when first_only=1.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 Latency SHALL be as follows, with the start edge as cycle 0:
- full search: done high in cycle 65;
- first_only with a match at k: done high in cycle k+2.
REQ-024 abort=1 in SEARCH SHALL return the FSM to IDLE at the next edge, with no done pulse and with partial found, sol_* and match_cnt retained.
REQ-025 abort in IDLE or DONE SHALL be ignored.
REQ-026 If abort and a match occur in the same cycle, abort SHALL win and the match SHALL NOT be counted.
REQ-027 A target greater than 9 SHALL simply yield no matches, with no error indication.
REQ-028 Results SHALL hold their values from DONE until the next accepted start.

Reset
REQ-029 rst_n low SHALL immediately force the following, including mid-search:
- state IDLE;
- busy, done and found to 0;
- sol_a, sol_b and sol_c to 0;
- match_cnt to 0;
- the candidate and latched target to 0.
REQ-030 The first start after reset release SHALL behave as in REQ-014.

Structure
REQ-031 Shared package subset_sum_pkg SHALL hold:
- the state enum {IDLE, SEARCH, DONE};
- IDX_MAX=3;
- NUM_CAND=64;
- IDX_W=5.
REQ-032 The match test SHALL be one instance of the existing combinational partial_sum checker, fed from registered candidate indices and the latched target.
REQ-033 There SHALL be no other sub-modules; the FSM, candidate counter and result registers SHALL be local.

Verification
REQ-034 target=3, first_only=0 SHALL give:
- done in cycle 65;
- match_cnt=8, found=1;
- sol=(0,1,2).
REQ-035 target=3, first_only=1 SHALL give done in cycle 8, match_cnt=1 and sol=(0,1,2).
REQ-036 target=0 SHALL give match_cnt=0 and found=0, since (0,0,0) fails the distinctness rule.
REQ-037 target=9 SHALL give a single match (3,3,3) at k=63, with done in cycle 65 in either mode.
REQ-038 Two stimuli SHALL be covered:
- start at cycle 0 and abort in cycle 5 -> IDLE in cycle 6 with no done pulse; a start pulse in cycle 3 has no effect;
- target=12 -> match_cnt=0.
REQ-039 rst_n pulsed low in cycle 20 of a search SHALL immediately zero all outputs; a new start then completes normally.
